// File: rtl/picosoc_mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding,
// watchdog width, forced read data and the per-master request bundle.
package picosoc_mem_arbiter_pkg;

  localparam int CNT_W = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// Saturating transfer-age counter; flags expiry on the last allowed cycle
// unless the slave completes in that same cycle.
module picosoc_bus_watchdog
  import picosoc_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic hit,
  output logic expired
);

  localparam logic             WD_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !hit && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = WD_ON && enable && !hit && (r_count == LIMIT);

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter onto a single picorv32-style memory port,
// with abort handling and a watchdog that force-completes stalled transfers.
module picosoc_mem_arbiter
  import picosoc_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          RESET_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        timeout_err,
  input  logic        err_clr
);

  logic [0:0]  r_state;
  logic        r_grant;
  logic        r_prio;
  logic        r_err;

  mem_req_t    w_m0;
  mem_req_t    w_m1;
  mem_req_t    w_sel;
  logic        w_busy;
  logic        w_live;
  logic        w_done;
  logic        w_expired;
  logic        w_finish;
  logic [31:0] w_rdata;

  assign w_m0  = '{valid: m0_valid, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_m1  = '{valid: m1_valid, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign w_sel = r_grant ? w_m1 : w_m0;

  // A granted master that drops valid aborts: nothing is forwarded that cycle.
  assign w_busy   = (r_state == ST_BUSY);
  assign w_live   = w_busy && w_sel.valid;
  assign w_done   = w_live && s_ready;
  assign w_finish = w_done || w_expired;

  picosoc_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_busy),
    .enable (w_live),
    .hit    (s_ready),
    .expired(w_expired)
  );

  assign s_valid  = w_live && !w_expired;
  assign s_addr   = w_sel.addr;
  assign s_wdata  = w_sel.wdata;
  assign s_wstrb  = w_sel.wstrb;

  assign w_rdata  = w_expired ? TIMEOUT_RDATA : s_rdata;
  assign m0_ready = w_finish && !r_grant;
  assign m1_ready = w_finish &&  r_grant;
  assign m0_rdata = w_rdata;
  assign m1_rdata = w_rdata;

  assign grant_id    = r_grant;
  assign timeout_err = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= RESET_PRIO;
      r_prio  <= RESET_PRIO;
      r_err   <= 1'b0;
    end else begin
      if (w_expired) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      if (!w_busy) begin
        if (m0_valid || m1_valid) begin
          r_state <= ST_BUSY;
          r_grant <= (m0_valid && m1_valid) ? r_prio : m1_valid;
        end
      end else if (w_finish) begin
        r_state <= ST_IDLE;
        r_prio  <= !r_grant;
      end else if (!w_sel.valid) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Directed scenarios plus random traffic, compared every cycle against a
// transaction-level model of the arbiter (owner, priority, transfer age).
module tb_picosoc_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_valid [2];
  logic [31:0] v_addr  [2];
  logic [31:0] v_wdata [2];
  logic [3:0]  v_wstrb [2];
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        grant_id, timeout_err;

  always #5 clk = ~clk;

  picosoc_mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .RESET_PRIO    (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (v_valid[0]),
    .m0_addr    (v_addr[0]),
    .m0_wdata   (v_wdata[0]),
    .m0_wstrb   (v_wstrb[0]),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (v_valid[1]),
    .m1_addr    (v_addr[1]),
    .m1_wdata   (v_wdata[1]),
    .m1_wstrb   (v_wstrb[1]),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant_id   (grant_id),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: is a transfer open, who owns it, who holds priority,
  // how many stalled cycles it has aged, and the sticky error flag.
  bit md_busy;
  int md_owner;
  int md_prio;
  int md_age;
  bit md_err;

  logic        obs_rdy   [2];
  logic [31:0] obs_rdata [2];
  logic        obs_sv, obs_err, obs_gid;
  int          ready_cnt [2];
  int          done_ids  [$];

  task automatic req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    v_valid[n] = 1'b1;
    v_addr[n]  = a;
    v_wdata[n] = d;
    v_wstrb[n] = s;
  endtask

  task automatic cycle();
    bit          gv, to_hit, fin, e_sv;
    logic [31:0] e_rdata;
    @(negedge clk);
    obs_rdy[0]   = m0_ready;
    obs_rdy[1]   = m1_ready;
    obs_rdata[0] = m0_rdata;
    obs_rdata[1] = m1_rdata;
    obs_sv       = s_valid;
    obs_err      = timeout_err;
    obs_gid      = grant_id;

    gv      = md_busy && v_valid[md_owner];
    to_hit  = gv && !s_ready && (TO != 0) && (md_age == TO - 1);
    fin     = (gv && s_ready) || to_hit;
    e_sv    = gv && !to_hit;
    e_rdata = to_hit ? 32'hFFFF_FFFF : s_rdata;

    check("s_valid",     32'(s_valid),     32'(e_sv));
    check("m0_ready",    32'(m0_ready),    32'(fin && md_owner == 0));
    check("m1_ready",    32'(m1_ready),    32'(fin && md_owner == 1));
    check("grant_id",    32'(grant_id),    32'(md_owner));
    check("timeout_err", 32'(timeout_err), 32'(md_err));
    if (e_sv) begin
      check("s_addr",  s_addr,         v_addr[md_owner]);
      check("s_wdata", s_wdata,        v_wdata[md_owner]);
      check("s_wstrb", 32'(s_wstrb),   32'(v_wstrb[md_owner]));
    end
    if (fin) begin
      if (md_owner == 0) check("m0_rdata", m0_rdata, e_rdata);
      else               check("m1_rdata", m1_rdata, e_rdata);
    end

    if (m0_ready) begin ready_cnt[0]++; done_ids.push_back(0); end
    if (m1_ready) begin ready_cnt[1]++; done_ids.push_back(1); end

    if (!md_busy) begin
      if (v_valid[0] || v_valid[1]) begin
        md_owner = (v_valid[0] && v_valid[1]) ? md_prio : (v_valid[1] ? 1 : 0);
        md_busy  = 1'b1;
        md_age   = 0;
      end
    end else if (fin) begin
      md_busy = 1'b0;
      md_prio = 1 - md_owner;
    end else if (!gv) begin
      md_busy = 1'b0;
    end else if (md_age < 65535) begin
      md_age++;
    end
    if (to_hit)       md_err = 1'b1;
    else if (err_clr) md_err = 1'b0;

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_ready = 1'b0;
    s_rdata = '0;
    err_clr = 1'b0;
    for (int n = 0; n < 2; n++) begin
      v_valid[n] = 1'b0; v_addr[n] = '0; v_wdata[n] = '0; v_wstrb[n] = '0;
      obs_rdy[n] = 1'b0; ready_cnt[n] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    md_busy  = 1'b0;
    md_owner = 0;
    md_prio  = 0;
    md_age   = 0;
    md_err   = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_s_valid", 32'(s_valid), 0);
    check("rst_grant",   32'(grant_id), 0);
    check("rst_err",     32'(timeout_err), 0);

    // Single m0 read completing on the third busy cycle.
    req(0, 32'h0000_0010, 32'h0, 4'h0);
    cycle();
    cycle();
    check("single_sv_b1", 32'(obs_sv), 1);
    cycle();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    cycle();
    check("single_m0_ready", 32'(obs_rdy[0]), 1);
    check("single_rdata",    obs_rdata[0], 32'h1234_5678);
    check("single_m1_ready", 32'(obs_rdy[1]), 0);
    v_valid[0] = 1'b0; s_ready = 1'b0;
    cycle();
    cycle();
    check("single_m0_pulses", 32'(ready_cnt[0]), 1);
    check("single_m1_pulses", 32'(ready_cnt[1]), 0);

    // Both masters saturating a zero-wait slave alternate grants.
    do_reset();
    done_ids.delete();
    req(0, 32'h100, 32'hA0, 4'h3);
    req(1, 32'h200, 32'hB0, 4'hC);
    s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
    repeat (16) cycle();
    check("fair_count", 32'(done_ids.size()), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < done_ids.size()) check($sformatf("fair_%0d", k), 32'(done_ids[k]), 32'(k % 2));
    end

    // m1 write with a silent slave expires on the fourth busy cycle.
    do_reset();
    req(1, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF);
    cycle();
    for (int b = 1; b <= 4; b++) begin
      cycle();
      if (b < 4) check("to_early_ready", 32'(obs_rdy[1]), 0);
    end
    check("to_m1_ready", 32'(obs_rdy[1]), 1);
    check("to_rdata",    obs_rdata[1], 32'hFFFF_FFFF);
    check("to_s_valid",  32'(obs_sv), 0);
    v_valid[1] = 1'b0;
    cycle();
    check("to_err_set", 32'(obs_err), 1);
    cycle();
    check("to_err_held", 32'(obs_err), 1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    check("to_err_cleared", 32'(obs_err), 0);

    // Slave completes exactly on the expiry cycle: normal completion wins.
    req(0, 32'h0000_0040, 32'h0, 4'h0);
    cycle();
    repeat (3) cycle();
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    cycle();
    check("coll_m0_ready", 32'(obs_rdy[0]), 1);
    check("coll_rdata",    obs_rdata[0], 32'hCAFE_F00D);
    v_valid[0] = 1'b0; s_ready = 1'b0;
    cycle();
    check("coll_err", 32'(obs_err), 0);

    // Abort keeps priority with the aborting master.
    do_reset();
    req(0, 32'h0000_0020, 32'h0, 4'h0);
    cycle();
    cycle();
    v_valid[0] = 1'b0;
    cycle();
    check("abort_s_valid", 32'(obs_sv), 0);
    check("abort_ready",   32'(obs_rdy[0]), 0);
    req(0, 32'h0000_0024, 32'h0, 4'h0);
    req(1, 32'h0000_0028, 32'h0, 4'h0);
    cycle();
    cycle();
    check("abort_keep_prio", 32'(obs_gid), 0);
    s_ready = 1'b1;
    cycle();
    v_valid[0] = 1'b0; v_valid[1] = 1'b0; s_ready = 1'b0;
    cycle();

    // Reset asserted mid-transfer clears outputs without a clock edge.
    do_reset();
    req(1, 32'h0000_0300, 32'h1111_2222, 4'hF);
    repeat (5) cycle();
    v_valid[1] = 1'b0;
    cycle();
    check("mid_err_before", 32'(obs_err), 1);
    req(1, 32'h0000_0304, 32'h3333_4444, 4'h5);
    cycle();
    cycle();
    s_ready = 1'b1;
    #1;
    check("mid_pre_ready", 32'(m1_ready), 1);
    check("mid_pre_grant", 32'(grant_id), 1);
    reset = 1'b1;
    #1;
    check("mid_s_valid",  32'(s_valid), 0);
    check("mid_m1_ready", 32'(m1_ready), 0);
    check("mid_m0_ready", 32'(m0_ready), 0);
    check("mid_grant",    32'(grant_id), 0);
    check("mid_err",      32'(timeout_err), 0);
    do_reset();

    // Random traffic with aborts, stalls, timeouts and error clears.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (obs_rdy[n]) v_valid[n] = 1'b0;
        else if (v_valid[n] && $urandom_range(0, 99) < 4) v_valid[n] = 1'b0;
        if (!v_valid[n] && $urandom_range(0, 99) < 40)
          req(n, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      s_ready = ($urandom_range(0, 99) < 35);
      s_rdata = $urandom;
      err_clr = ($urandom_range(0, 99) < 10);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
